// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR test datapath: data width, checker states
// and the 32-bit-per-cycle PRBS31 step used by generator and checker alike.
package ddr_test_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_CHECK = 2'd2
  } chk_state_t;

  // Every next-state bit is a function of the old state only.
  function automatic logic [DATA_W-1:0] prbs31_step(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] n;
    n[0] = d[24] ^ d[30];
    n[1] = d[0] ^ d[25] ^ d[28];
    n[2] = d[1] ^ d[26] ^ d[29];
    n[3] = d[2] ^ d[27] ^ d[30];
    for (int k = 4; k < DATA_W; k++) begin
      n[k] = d[k-4] ^ d[k-1];
    end
    return n;
  endfunction

endpackage

// File: rtl/ddr_popcount32.sv
// Registered 32-bit population count, one cycle of latency.
module ddr_popcount32
  import ddr_test_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  output logic [5:0]        o_cnt
);

  logic [5:0] w_sum;
  logic [5:0] r_cnt;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_sum = w_sum + 6'(i_data[i]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= w_sum;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ddr_prbs31_chk.sv
// PRBS31 read-back checker: regenerates the expected stream, tracks lock,
// counts word/bit errors and captures the first mismatch.
module ddr_prbs31_chk
  import ddr_test_pkg::*;
#(
  parameter logic [DATA_W-1:0] DATA_INIT   = 32'hffff_ffff,
  parameter int                LOSS_THRESH = 8,
  parameter int                CNT_W       = 32
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              chk_en,
  input  logic              seed_mode,
  input  logic              clr,
  input  logic              rd_vld,
  input  logic [DATA_W-1:0] rd_data,
  output logic              chk_locked,
  output logic              err_flag,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_word_cnt,
  output logic [CNT_W-1:0]  err_bit_cnt,
  output logic              first_err_vld,
  output logic [DATA_W-1:0] first_err_data,
  output logic [DATA_W-1:0] first_err_exp
);

  localparam int             SW     = ((CNT_W > 6) ? CNT_W : 6) + 1;
  localparam logic [SW-1:0]  SAT    = SW'({CNT_W{1'b1}});
  localparam logic [8:0]     LOSS_T = 9'(LOSS_THRESH);

  chk_state_t        r_state, w_state_next;
  logic [DATA_W-1:0] r_exp;
  logic [7:0]        r_miss;
  logic              r_err_flag, r_first_vld;
  logic [CNT_W-1:0]  r_word_cnt, r_err_word_cnt, r_err_bit_cnt;
  logic [DATA_W-1:0] r_first_data, r_first_exp;

  logic              w_cmp, w_mis, w_hit, w_loss;
  logic              w_load_preset, w_load_seed;
  logic [DATA_W-1:0] w_diff, w_pop_in;
  logic [5:0]        w_pop;
  logic [SW-1:0]     w_bit_sum;

  assign w_cmp  = (r_state == ST_CHECK) && chk_en && rd_vld;
  assign w_diff = rd_data ^ r_exp;
  assign w_mis  = w_cmp && !clr && (w_diff != '0);
  assign w_hit  = w_cmp && !clr && (w_diff == '0);
  assign w_loss = w_mis && (({1'b0, r_miss} + 9'd1) >= LOSS_T);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_load_preset = 1'b0;
    w_load_seed   = 1'b0;
    if (!chk_en) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (seed_mode) begin
            w_state_next = ST_SEED;
          end else begin
            w_state_next  = ST_CHECK;
            w_load_preset = 1'b1;
          end
        end
        ST_SEED: begin
          if (rd_vld) begin
            w_state_next = ST_CHECK;
            w_load_seed  = 1'b1;
          end
        end
        ST_CHECK: begin
          // Resync after loss of lock always self-seeds.
          if (w_loss) w_state_next = ST_SEED;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_exp  <= DATA_INIT;
      r_miss <= '0;
    end else begin
      if (w_load_preset)    r_exp <= prbs31_step(DATA_INIT);
      else if (w_load_seed) r_exp <= prbs31_step(rd_data);
      else if (w_cmp)       r_exp <= prbs31_step(r_exp);

      if (r_state != ST_CHECK || w_loss || w_hit) r_miss <= '0;
      else if (w_mis)                             r_miss <= r_miss + 8'd1;
    end
  end

  // Only mismatched words feed the popcount; everything else adds zero.
  assign w_pop_in  = w_mis ? w_diff : '0;
  assign w_bit_sum = SW'(r_err_bit_cnt) + SW'(w_pop);

  ddr_popcount32 u_popcount (
    .i_clk  (clk_sys),
    .i_rst  (reset),
    .i_data (w_pop_in),
    .o_cnt  (w_pop)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_err_flag     <= 1'b0;
      r_word_cnt     <= '0;
      r_err_word_cnt <= '0;
      r_err_bit_cnt  <= '0;
      r_first_vld    <= 1'b0;
      r_first_data   <= '0;
      r_first_exp    <= '0;
    end else if (clr) begin
      r_err_flag     <= 1'b0;
      r_word_cnt     <= '0;
      r_err_word_cnt <= '0;
      r_err_bit_cnt  <= '0;
      r_first_vld    <= 1'b0;
      r_first_data   <= '0;
      r_first_exp    <= '0;
    end else begin
      r_err_flag <= w_mis;
      if (w_cmp && (r_word_cnt != {CNT_W{1'b1}}))
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      if (w_mis && (r_err_word_cnt != {CNT_W{1'b1}}))
        r_err_word_cnt <= r_err_word_cnt + CNT_W'(1);
      r_err_bit_cnt <= (w_bit_sum > SAT) ? {CNT_W{1'b1}} : w_bit_sum[CNT_W-1:0];
      if (w_mis && !r_first_vld) begin
        r_first_vld  <= 1'b1;
        r_first_data <= rd_data;
        r_first_exp  <= r_exp;
      end
    end
  end

  assign chk_locked     = (r_state == ST_CHECK);
  assign err_flag       = r_err_flag;
  assign word_cnt       = r_word_cnt;
  assign err_word_cnt   = r_err_word_cnt;
  assign err_bit_cnt    = r_err_bit_cnt;
  assign first_err_vld  = r_first_vld;
  assign first_err_data = r_first_data;
  assign first_err_exp  = r_first_exp;

endmodule

// File: tb/tb_ddr_prbs31_chk.sv
// Directed bench for ddr_prbs31_chk: default instance plus a narrow-counter
// instance (CNT_W=4, LOSS_THRESH=255) for saturation and clear.
module tb_ddr_prbs31_chk;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        chk_en = 1'b0, seed_mode = 1'b0, clr = 1'b0, rd_vld = 1'b0;
  logic [31:0] rd_data = '0;

  logic        chk_locked, err_flag, first_err_vld;
  logic [31:0] word_cnt, err_word_cnt, err_bit_cnt, first_err_data, first_err_exp;

  logic        s_locked, s_err_flag, s_first_vld;
  logic [3:0]  s_word_cnt, s_err_word_cnt, s_err_bit_cnt;
  logic [31:0] s_first_data, s_first_exp;

  always #5 clk_sys = ~clk_sys;

  ddr_prbs31_chk dut (
    .clk_sys(clk_sys), .reset(reset), .chk_en(chk_en), .seed_mode(seed_mode),
    .clr(clr), .rd_vld(rd_vld), .rd_data(rd_data),
    .chk_locked(chk_locked), .err_flag(err_flag), .word_cnt(word_cnt),
    .err_word_cnt(err_word_cnt), .err_bit_cnt(err_bit_cnt),
    .first_err_vld(first_err_vld), .first_err_data(first_err_data),
    .first_err_exp(first_err_exp)
  );

  ddr_prbs31_chk #(.LOSS_THRESH(255), .CNT_W(4)) dut_sat (
    .clk_sys(clk_sys), .reset(reset), .chk_en(chk_en), .seed_mode(seed_mode),
    .clr(clr), .rd_vld(rd_vld), .rd_data(rd_data),
    .chk_locked(s_locked), .err_flag(s_err_flag), .word_cnt(s_word_cnt),
    .err_word_cnt(s_err_word_cnt), .err_bit_cnt(s_err_bit_cnt),
    .first_err_vld(s_first_vld), .first_err_data(s_first_data),
    .first_err_exp(s_first_exp)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %s = %h", tag, obs);
    end else begin
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference step written in shifted-slice form.
  function automatic logic [31:0] tb_step(input logic [31:0] d);
    logic [31:0] n;
    n[31:4] = d[27:0] ^ d[30:3];
    n[0] = d[24] ^ d[30];
    n[1] = d[0] ^ d[25] ^ d[28];
    n[2] = d[1] ^ d[26] ^ d[29];
    n[3] = d[2] ^ d[27] ^ d[30];
    return n;
  endfunction

  function automatic logic [31:0] gen();
    g = tb_step(g);
    return g;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    rd_vld  = 1'b1;
    rd_data = d;
    tick();
    rd_vld  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; chk_en = 1'b0; seed_mode = 1'b0; clr = 1'b0;
    rd_vld = 1'b0; rd_data = '0;
    tick();
    tick();
    reset = 1'b0;
    g = 32'hffff_ffff;
  endtask

  initial begin
    int          drops;
    int          sum;
    logic [31:0] w;
    logic [31:0] bad_exp;

    // Preset, clean stream with random gaps
    do_reset();
    check("rst_locked", 32'(chk_locked), 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);
    check("rst_word_cnt", word_cnt, 32'd0);
    check("rst_err_word", err_word_cnt, 32'd0);
    check("rst_err_bit", err_bit_cnt, 32'd0);
    check("rst_first_vld", 32'(first_err_vld), 32'd0);
    check("rst_first_data", first_err_data, 32'd0);
    check("rst_first_exp", first_err_exp, 32'd0);
    chk_en = 1'b1;
    tick();
    check("preset_lock", 32'(chk_locked), 32'd1);
    drops = 0;
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        tick();
        if (!chk_locked) drops++;
      end
      send(gen());
      if (!chk_locked) drops++;
    end
    tick();
    check("clean_word_cnt", word_cnt, 32'd1000);
    check("clean_err_word", err_word_cnt, 32'd0);
    check("clean_err_bit", err_bit_cnt, 32'd0);
    check("clean_lock_drops", 32'(drops), 32'd0);

    // Single-bit error on word 100
    do_reset();
    chk_en = 1'b1;
    tick();
    bad_exp = '0;
    for (int i = 0; i < 150; i++) begin
      w = gen();
      if (i == 100) begin
        bad_exp = w;
        send(w ^ 32'h20);
        check("sbe_err_flag", 32'(err_flag), 32'd1);
        check("sbe_first_vld_now", 32'(first_err_vld), 32'd1);
        check("sbe_bit_latency", err_bit_cnt, 32'd0);
        tick();
        check("sbe_bit_landed", err_bit_cnt, 32'd1);
        check("sbe_flag_pulse", 32'(err_flag), 32'd0);
      end else begin
        send(w);
      end
    end
    tick();
    check("sbe_err_word", err_word_cnt, 32'd1);
    check("sbe_err_bit", err_bit_cnt, 32'd1);
    check("sbe_first_xor", first_err_data ^ first_err_exp, 32'h20);
    check("sbe_first_exp", first_err_exp, bad_exp);
    check("sbe_first_vld", 32'(first_err_vld), 32'd1);
    check("sbe_locked", 32'(chk_locked), 32'd1);
    check("sbe_word_cnt", word_cnt, 32'd150);

    // Self-seed mid-stream
    do_reset();
    for (int i = 0; i < 37; i++) send(gen());
    chk_en = 1'b1;
    seed_mode = 1'b1;
    tick();
    check("seed_wait_unlocked", 32'(chk_locked), 32'd0);
    for (int i = 0; i < 500; i++) begin
      send(gen());
      if (i == 0) check("seed_lock_first", 32'(chk_locked), 32'd1);
    end
    tick();
    check("seed_word_cnt", word_cnt, 32'd499);
    check("seed_err_word", err_word_cnt, 32'd0);
    check("seed_err_bit", err_bit_cnt, 32'd0);

    // Loss of lock and relock
    do_reset();
    chk_en = 1'b1;
    seed_mode = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) send(gen());
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      w = gen();
      sum += $countones(w);
      send(32'h0);
      if (i == 6) check("lol_lock_7th", 32'(chk_locked), 32'd1);
      if (i == 7) check("lol_unlock_8th", 32'(chk_locked), 32'd0);
    end
    check("lol_err_word", err_word_cnt, 32'd8);
    tick();
    check("lol_err_bit", err_bit_cnt, 32'(sum));
    send(gen());
    check("lol_relock", 32'(chk_locked), 32'd1);
    for (int i = 0; i < 50; i++) send(gen());
    tick();
    check("lol_err_word_after", err_word_cnt, 32'd8);
    check("lol_word_cnt", word_cnt, 32'd78);
    check("lol_err_bit_after", err_bit_cnt, 32'(sum));

    // Saturation and clear on the narrow instance
    do_reset();
    chk_en = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) send(~gen());
    tick();
    check("sat_err_word", 32'(s_err_word_cnt), 32'd15);
    check("sat_err_bit", 32'(s_err_bit_cnt), 32'd15);
    check("sat_word_cnt", 32'(s_word_cnt), 32'd15);
    check("sat_locked", 32'(s_locked), 32'd1);
    rd_vld = 1'b1;
    rd_data = ~gen();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    rd_vld = 1'b0;
    check("clr_word_cnt", 32'(s_word_cnt), 32'd0);
    check("clr_err_word", 32'(s_err_word_cnt), 32'd0);
    check("clr_err_bit", 32'(s_err_bit_cnt), 32'd0);
    check("clr_first_vld", 32'(s_first_vld), 32'd0);
    check("clr_first_data", s_first_data, 32'd0);
    check("clr_err_flag", 32'(s_err_flag), 32'd0);
    tick();
    check("clr_err_bit_next", 32'(s_err_bit_cnt), 32'd0);
    check("clr_locked", 32'(s_locked), 32'd1);
    send(~gen());
    check("clr_post_err_word", 32'(s_err_word_cnt), 32'd1);
    check("clr_post_first_vld", 32'(s_first_vld), 32'd1);

    // Asynchronous reset between edges
    do_reset();
    chk_en = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) send(gen());
    send(gen() ^ 32'h0000_00ff);
    send(gen());
    #2 reset = 1'b1;
    #1;
    check("arst_locked", 32'(chk_locked), 32'd0);
    check("arst_word_cnt", word_cnt, 32'd0);
    check("arst_err_word", err_word_cnt, 32'd0);
    check("arst_err_bit", err_bit_cnt, 32'd0);
    check("arst_first_vld", 32'(first_err_vld), 32'd0);
    check("arst_first_data", first_err_data, 32'd0);
    check("arst_first_exp", first_err_exp, 32'd0);
    #2 reset = 1'b0;
    g = 32'hffff_ffff;
    tick();
    check("arst_idle_exit", 32'(chk_locked), 32'd1);
    for (int i = 0; i < 20; i++) send(gen());
    tick();
    check("arst_word_cnt_after", word_cnt, 32'd20);
    check("arst_err_word_after", err_word_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
